mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 33 +++
 rtl/mem_responder_if.sv | 39 +++
 rtl/mem_responder_line_merge.sv | 21 ++
 rtl/mem_responder.sv | 131 +++++++++++++
 tb/tb_mem_responder.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared LC-3b memory types plus line-buffer helpers
// used by the single-line memory responder.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [1:0]   lc3b_mem_wmask;
    typedef logic [127:0] lc3b_line;
    typedef logic [11:0]  lc3b_tag;
    typedef logic [2:0]   lc3b_offset;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_RESP
    } resp_state_t;

    typedef struct packed {
        lc3b_tag       tag;
        lc3b_offset    off;
        lc3b_mem_wmask be;
        lc3b_word      wdata;
        logic          wr;
    } mem_req_t;

    function automatic lc3b_word line_word(
        lc3b_line   l,
        lc3b_offset o
    );
        return l[{o, 4'd0} +: 16];
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Initiator-side and physical-side buses of the
// memory responder.
interface mem_responder_if;
    import lc3b_types::*;

    logic          mem_read;
    logic          mem_write;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    logic          mem_resp;
    lc3b_word      mem_rdata;

    logic          pmem_read;
    logic          pmem_write;
    lc3b_word      pmem_address;
    lc3b_line      pmem_wdata;
    logic          pmem_resp;
    lc3b_line      pmem_rdata;

    modport slave (
        input  mem_read, mem_write, mem_byte_enable,
        input  mem_address, mem_wdata,
        output mem_resp, mem_rdata,
        output pmem_read, pmem_write,
        output pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable,
        output mem_address, mem_wdata,
        input  mem_resp, mem_rdata,
        input  pmem_read, pmem_write,
        input  pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata
    );

endinterface

// File: rtl/mem_responder_line_merge.sv
// Byte-masked merge of one 16-bit word into a
// 128-bit line.
module line_merge
    import lc3b_types::*;
(
    input  lc3b_line      line_in,
    input  lc3b_offset    offset,
    input  lc3b_mem_wmask wmask,
    input  lc3b_word      word,
    output lc3b_line      line_out
);

    always_comb begin
        line_out = line_in;
        if (wmask[0])
            line_out[{offset, 4'd0} +: 8] = word[7:0];
        if (wmask[1])
            line_out[{offset, 4'd8} +: 8] = word[15:8];
    end

endmodule

// File: rtl/mem_responder.sv
// Single-line write-through buffer between a word
// initiator and a 128-bit line memory.
module mem_responder
    import lc3b_types::*;
(
    input  logic clk,
    input  logic rst_n,
    mem_responder_if.slave bus
);

    resp_state_t   state;
    logic          valid;
    lc3b_tag       tag;
    lc3b_line      line;
    mem_req_t      req_q;

    logic          req;
    logic          hit;
    lc3b_tag       in_tag;
    lc3b_offset    in_off;
    logic          addr_lsb_unused;

    lc3b_line      m_base;
    lc3b_offset    m_off;
    lc3b_mem_wmask m_be;
    lc3b_word      m_word;
    lc3b_line      m_line;

    assign req    = bus.mem_read | bus.mem_write;
    assign in_tag = bus.mem_address[15:4];
    assign in_off = bus.mem_address[3:1];
    assign hit    = valid && (tag == in_tag);
    // Byte lane select is irrelevant for word access.
    assign addr_lsb_unused = bus.mem_address[0];

    // A write hit merges the live request; after a
    // fill it merges the latched request into the
    // incoming line.
    always_comb begin
        m_base = line;
        m_off  = req_q.off;
        m_be   = req_q.be;
        m_word = req_q.wdata;
        unique case (state)
            S_IDLE: begin
                m_off  = in_off;
                m_be   = bus.mem_byte_enable;
                m_word = bus.mem_wdata;
            end
            S_FILL:  m_base = bus.pmem_rdata;
            default: ;
        endcase
    end

    line_merge u_merge (
        .line_in  (m_base),
        .offset   (m_off),
        .wmask    (m_be),
        .word     (m_word),
        .line_out (m_line)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            valid            <= 1'b0;
            tag              <= '0;
            line             <= '0;
            req_q            <= '0;
            bus.mem_resp     <= 1'b0;
            bus.mem_rdata    <= '0;
            bus.pmem_read    <= 1'b0;
            bus.pmem_write   <= 1'b0;
            bus.pmem_address <= '0;
            bus.pmem_wdata   <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (req) begin
                    req_q.tag        <= in_tag;
                    req_q.off        <= in_off;
                    req_q.be         <= bus.mem_byte_enable;
                    req_q.wdata      <= bus.mem_wdata;
                    req_q.wr         <= bus.mem_write;
                    bus.pmem_address <= {in_tag, 4'h0};
                    if (!hit) begin
                        state         <= S_FILL;
                        bus.pmem_read <= 1'b1;
                    end else if (bus.mem_write) begin
                        state          <= S_WRITE;
                        bus.pmem_write <= 1'b1;
                        bus.pmem_wdata <= m_line;
                    end else begin
                        state         <= S_RESP;
                        bus.mem_resp  <= 1'b1;
                        bus.mem_rdata <= line_word(line, in_off);
                    end
                end
                S_FILL: if (bus.pmem_resp) begin
                    bus.pmem_read <= 1'b0;
                    valid         <= 1'b1;
                    tag           <= req_q.tag;
                    line          <= bus.pmem_rdata;
                    if (req_q.wr) begin
                        state          <= S_WRITE;
                        bus.pmem_write <= 1'b1;
                        bus.pmem_wdata <= m_line;
                    end else begin
                        state         <= S_RESP;
                        bus.mem_resp  <= 1'b1;
                        bus.mem_rdata <=
                            line_word(bus.pmem_rdata, req_q.off);
                    end
                end
                S_WRITE: if (bus.pmem_resp) begin
                    bus.pmem_write <= 1'b0;
                    line           <= bus.pmem_wdata;
                    state          <= S_RESP;
                    bus.mem_resp   <= 1'b1;
                    bus.mem_rdata  <=
                        line_word(bus.pmem_wdata, req_q.off);
                end
                S_RESP: begin
                    bus.mem_resp <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder with a
// delay-programmable line-memory responder.
module tb_mem_responder;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if bus ();

    mem_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit       wr;
        lc3b_word addr;
        lc3b_line data;
    } pm_t;

    int checks = 0;
    int errors = 0;

    lc3b_line mem [int];
    pm_t      pm_q [$];
    lc3b_word rd_q [$];

    bit       m_valid = 1'b0;
    lc3b_tag  m_tag = '0;
    lc3b_line m_line = '0;

    int       pm_delay = 0;
    bit       stray = 1'b0;

    pm_t      pe;
    bit       pe_wr;
    lc3b_word pe_a;
    lc3b_line pe_d;
    bit       pe_live;

    lc3b_tag  tags [4] = '{12'h123, 12'h200, 12'h400, 12'h500};

    task automatic chk(string tag, logic [127:0] got,
                       logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic lc3b_line mem_line(lc3b_tag t);
        lc3b_line l;
        if (mem.exists(int'(t)))
            return mem[int'(t)];
        for (int i = 0; i < 8; i++)
            l[i*16 +: 16] = {t, 3'(i), 1'b1};
        return l;
    endfunction

    function automatic lc3b_line merge(lc3b_line l,
        lc3b_offset o, lc3b_mem_wmask be, lc3b_word w);
        lc3b_word old;
        old = l[int'(o)*16 +: 16];
        l[int'(o)*16 +: 16] = {be[1] ? w[15:8] : old[15:8],
                               be[0] ? w[7:0]  : old[7:0]};
        return l;
    endfunction

    task automatic model(bit wr, lc3b_word a,
        lc3b_mem_wmask be, lc3b_word w, output bit hit);
        lc3b_tag    t;
        lc3b_offset o;
        t   = a[15:4];
        o   = a[3:1];
        hit = m_valid && (m_tag == t);
        if (!hit) begin
            m_line  = mem_line(t);
            m_tag   = t;
            m_valid = 1'b1;
            pm_q.push_back('{1'b0, {t, 4'h0}, m_line});
        end
        if (wr) begin
            m_line = merge(m_line, o, be, w);
            mem[int'(t)] = m_line;
            pm_q.push_back('{1'b1, {t, 4'h0}, m_line});
        end
        rd_q.push_back(m_line[int'(o)*16 +: 16]);
    endtask

    task automatic access(bit rd, bit wr, lc3b_word a,
        lc3b_mem_wmask be, lc3b_word w, string tag);
        bit       hit;
        lc3b_word exp;
        int       n;
        model(wr, a, be, w, hit);
        @(negedge clk);
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_address     = a;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = w;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.mem_resp && n < 500);
        exp = rd_q.pop_front();
        chk({tag, "_resp"}, bus.mem_resp, 1'b1);
        chk({tag, "_rdata"}, bus.mem_rdata, exp);
        if (hit && !wr)
            chk({tag, "_lat"}, n, 1);
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, bus.mem_resp, 1'b0);
        chk({tag, "_hold"}, bus.mem_rdata, exp);
        chk({tag, "_pmq"}, pm_q.size(), 0);
    endtask

    // Physical memory: serves the op at the head of
    // the scoreboard queue after pm_delay idle cycles.
    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (rst_n && (bus.pmem_read || bus.pmem_write)) begin
                chk("pm_excl", bus.pmem_read & bus.pmem_write, 1'b0);
                chk("pm_expected", pm_q.size() != 0, 1'b1);
                if (pm_q.size() != 0)
                    pe = pm_q.pop_front();
                else
                    pe = '{bus.pmem_write, bus.pmem_address, '0};
                pe_wr = bus.pmem_write;
                pe_a  = bus.pmem_address;
                pe_d  = bus.pmem_wdata;
                chk("pm_op", pe_wr, pe.wr);
                chk("pm_addr", pe_a, pe.addr);
                if (pe_wr)
                    chk("pm_wdata", pe_d, pe.data);
                pe_live = 1'b1;
                for (int i = 0; i < pm_delay && pe_live; i++) begin
                    @(negedge clk);
                    if (!rst_n || !(bus.pmem_read || bus.pmem_write))
                        pe_live = 1'b0;
                    else begin
                        chk("pm_hold_addr", bus.pmem_address, pe_a);
                        chk("pm_hold_op", bus.pmem_write, pe_wr);
                        chk("pm_hold_wdata", bus.pmem_wdata, pe_d);
                        chk("pm_no_resp", bus.mem_resp, 1'b0);
                    end
                end
                if (pe_live) begin
                    if (!pe_wr)
                        bus.pmem_rdata = pe.data;
                    bus.pmem_resp = 1'b1;
                end
            end else if (stray) begin
                bus.pmem_resp = 1'b1;
                stray = 1'b0;
            end
        end
    end

    initial begin
        lc3b_line l;
        lc3b_word a;
        bit       r;
        bit       w;

        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = '0;
        bus.mem_byte_enable = '0;
        bus.mem_wdata       = '0;

        l = mem_line(12'h123);
        l[47:32] = 16'hBEEF;
        l[63:48] = 16'hC0DE;
        mem[32'h123] = l;
        l = mem_line(12'h200);
        l[15:0] = 16'h1111;
        mem[32'h200] = l;

        #12;
        chk("rst_mem_resp", bus.mem_resp, 1'b0);
        chk("rst_mem_rdata", bus.mem_rdata, 16'h0);
        chk("rst_pmem_read", bus.pmem_read, 1'b0);
        chk("rst_pmem_write", bus.pmem_write, 1'b0);
        chk("rst_pmem_addr", bus.pmem_address, 16'h0);
        chk("rst_pmem_wdata", bus.pmem_wdata, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        access(1, 0, 16'h1234, 2'b00, 16'h0, "rd_miss");
        chk("rd_miss_beef", bus.mem_rdata, 16'hBEEF);
        access(1, 0, 16'h1236, 2'b00, 16'h0, "rd_hit");
        chk("rd_hit_w3", bus.mem_rdata, 16'hC0DE);
        access(0, 1, 16'h1234, 2'b01, 16'h55AA, "wr_hit");
        access(1, 0, 16'h1234, 2'b00, 16'h0, "rd_after_wr");
        chk("rd_after_wr_val", bus.mem_rdata, 16'hBEAA);
        access(0, 1, 16'h2000, 2'b10, 16'h7700, "wr_miss");
        chk("wr_miss_val", bus.mem_rdata, 16'h7711);
        access(0, 1, 16'h2004, 2'b00, 16'hFFFF, "wr_be0");
        access(1, 1, 16'h2006, 2'b11, 16'hA5A5, "rd_wr");
        access(1, 0, 16'h2001, 2'b00, 16'h0, "odd_addr");
        chk("odd_addr_val", bus.mem_rdata, 16'h7711);

        @(negedge clk);
        stray = 1'b1;
        repeat (3) @(negedge clk);
        chk("stray_pmem_read", bus.pmem_read, 1'b0);
        chk("stray_pmem_write", bus.pmem_write, 1'b0);
        chk("stray_mem_resp", bus.mem_resp, 1'b0);
        access(1, 0, 16'h2006, 2'b00, 16'h0, "stray_rd");

        pm_delay = 10;
        access(1, 0, 16'h4002, 2'b00, 16'h0, "slow_rd");
        access(0, 1, 16'h400C, 2'b11, 16'h1357, "slow_wr");

        for (int k = 0; k < 24; k++) begin
            pm_delay = $urandom_range(0, 3);
            a = {tags[$urandom_range(0, 3)], 4'($urandom)};
            r = 1'($urandom);
            w = 1'($urandom);
            if (!r && !w)
                r = 1'b1;
            access(r, w, a, 2'($urandom), 16'($urandom), "rnd");
        end

        pm_delay = 10;
        pm_q.push_back('{1'b0, 16'h3000, mem_line(12'h300)});
        @(negedge clk);
        bus.mem_read    = 1'b1;
        bus.mem_write   = 1'b0;
        bus.mem_address = 16'h3000;
        @(posedge clk);
        #1;
        chk("abort_pmem_read_on", bus.pmem_read, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_pmem_read_off", bus.pmem_read, 1'b0);
        chk("abort_pmem_addr", bus.pmem_address, 16'h0);
        chk("abort_mem_resp", bus.mem_resp, 1'b0);
        bus.mem_read = 1'b0;
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        pm_delay = 0;
        chk("abort_pmq", pm_q.size(), 0);
        rst_n = 1'b1;
        access(1, 0, 16'h1234, 2'b00, 16'h0, "reread");
        chk("reread_val", bus.mem_rdata, 16'hBEAA);

        repeat (3) @(negedge clk);
        chk("end_pmq", pm_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
